// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Pipelined integer ALU with a valid/ready request side and a
//            valid/ready result side. Single-cycle ops return their result one
//            cycle after acceptance. An optional iterative shift-add
//            multiplier (MUL / MULHU) is built only when the macro
//            ALU_PIPE_MUL_EN is defined. Without it, uops 0101/0110 return 0
//            in one cycle and busy_out is tied low.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameter : DATA_WIDTH  operand/result width (power of two, >= 8)
// Ports     : clk_in      clock, rising edge
//             rst_n_in    asynchronous active-low reset
//             valid_in    request valid        ready_out  request accepted
//             a_data_in   operand A            b_data_in  operand B / imm
//             uop_in      micro-opcode
//             valid_out   result valid         ready_in   result consumed
//             result_out  registered result    busy_out   multiply running
// ============================================================================
module alu_pipe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [DATA_WIDTH-1:0] a_data_in,
    input  logic [DATA_WIDTH-1:0] b_data_in,
    input  logic [3:0]            uop_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  busy_out
);

    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;

    logic                    accept;
    logic                    consume;
    logic                    is_mul;
    logic                    mul_done;
    logic [DATA_WIDTH-1:0]   mul_res;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic [SHW-1:0]          shamt;

    assign ready_out  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && ready_in);
    assign accept     = valid_in && ready_out;
    assign consume    = valid_q && ready_in;
    assign valid_out  = valid_q;
    assign result_out = result_q;

    // Single-cycle datapath, evaluated on the live inputs so the result is
    // captured on the accepting edge.
    always_comb begin
        shamt   = b_data_in[SHW-1:0];
        alu_res = '0;
        case (uop_in)
            4'b0000: alu_res = a_data_in + b_data_in;
            4'b0001: alu_res = a_data_in - b_data_in;
            4'b0010: alu_res = a_data_in | b_data_in;
            4'b0011: alu_res = a_data_in & b_data_in;
            4'b0100: alu_res = a_data_in ^ b_data_in;
            4'b1000: alu_res = a_data_in;
            4'b1001: alu_res = b_data_in;
            4'b1010: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_data_in) < $signed(b_data_in))};
            4'b1011: alu_res = {{(DATA_WIDTH-1){1'b0}}, (a_data_in < b_data_in)};
            4'b1101: alu_res = $unsigned($signed(a_data_in) >>> shamt);
            4'b1110: alu_res = a_data_in >> shamt;
            4'b1111: alu_res = a_data_in << shamt;
            default: alu_res = '0;  // 0101/0110 without multiplier, 0111, 1100
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    // Shift-add multiplier: {hi,lo} starts as {0,B}; each cycle adds A into hi
    // when lo[0] is set, then shifts the (W+1)-bit sum and lo right by one.
    // After DATA_WIDTH iterations {hi,lo} holds the full 2W-bit product.
    localparam logic [SHW-1:0] CNT_LAST = SHW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [SHW-1:0]        cnt_q, cnt_d;
    logic                  sel_hi_q, sel_hi_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH:0]   mul_sum;

    assign is_mul   = (uop_in == 4'b0101) || (uop_in == 4'b0110);
    assign mul_done = (state_q == ST_MUL) && (cnt_q == CNT_LAST);
    assign busy_out = busy_q;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(DATA_WIDTH+1){1'b0}});
        mul_res  = sel_hi_q ? mul_sum[DATA_WIDTH:1] : {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        sel_hi_d = sel_hi_q;
        if (state_q == ST_MUL) begin
            hi_d  = mul_sum[DATA_WIDTH:1];
            lo_d  = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
        end else if (accept && is_mul) begin
            mcand_d  = a_data_in;
            hi_d     = '0;
            lo_d     = b_data_in;
            cnt_d    = '0;
            sel_hi_d = uop_in[1];  // 0110 selects the high half
        end
        busy_d = (state_d == ST_MUL);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            sel_hi_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            sel_hi_q <= sel_hi_d;
            busy_q   <= busy_d;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign busy_out = 1'b0;
`endif

    // Control: the last multiply iteration writes the result directly, so
    // valid_out rises on the edge that completes the final iteration.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        result_d = result_q;
        if (state_q == ST_MUL) begin
            if (mul_done) begin
                state_d  = ST_HOLD;
                valid_d  = 1'b1;
                result_d = mul_res;
            end
        end else if (accept) begin
            if (is_mul) begin
                state_d = ST_MUL;
                valid_d = 1'b0;
            end else begin
                state_d  = ST_HOLD;
                valid_d  = 1'b1;
                result_d = alu_res;
            end
        end else if (consume) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; SHALL be a power of two, >= 8.
REQ-002 clk_in  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 valid_in  input  1  operation request valid.
REQ-005 ready_out  output  1  block can accept a request this cycle.
REQ-006 a_data_in  input  DATA_WIDTH  operand A (rs1).
REQ-007 b_data_in  input  DATA_WIDTH  operand B (rs2/imm).
REQ-008 uop_in  input  4  micro-opcode.
REQ-009 valid_out  output  1  result_out holds a valid result.
REQ-010 ready_in  input  1  consumer accepts result this cycle.
REQ-011 result_out  output  DATA_WIDTH  registered result.
REQ-012 busy_out  output  1  multi-cycle operation in progress.

Function
REQ-013 Request SHALL be accepted on a rising edge where valid_in && ready_out; result consumed on edge where valid_out && ready_in.
REQ-014 uop encoding: 0000 ADD, 0001 SUB, 0010 OR, 0011 AND, 0100 XOR, 1000 pass A, 1001 pass B, 1010 SLT (signed), 1011 SLTU, 1101 SRA, 1110 SRL, 1111 SLL; 0101/0110 per REQ-026; 0111, 1100 SHALL yield 0.
REQ-015 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; no flags.
REQ-016 SLT/SLTU SHALL yield 1 or 0 zero-extended to DATA_WIDTH.
REQ-017 Shift amount SHALL be b_data_in[log2(DATA_WIDTH)-1:0]; upper B bits ignored; SRA SHALL replicate A's MSB.
REQ-018 Single-cycle ops: result SHALL be registered into result_out with valid_out high in the cycle after acceptance (latency 1).
REQ-019 Operands and uop SHALL be captured at acceptance; later input changes SHALL NOT affect an in-flight result.
REQ-020 FSM states IDLE, MUL, HOLD; IDLE->HOLD on single-cycle accept; IDLE->MUL on multiply accept; MUL->HOLD after final iteration; HOLD->IDLE on consume with no new accept; HOLD->HOLD or HOLD->MUL on consume with simultaneous accept.
REQ-021 ready_out SHALL equal (state==IDLE) || (state==HOLD && ready_in); ready_out SHALL be 0 in MUL.
REQ-022 Back-to-back single-cycle ops with ready_in held high SHALL sustain one result per cycle.
REQ-023 With ready_in low, result_out and valid_out SHALL hold stable until consumed.
REQ-024 busy_out SHALL be 1 exactly while state==MUL.
REQ-025 result_out SHALL retain last value when valid_out is low.

Reset
REQ-026a rst_n_in low SHALL immediately force state IDLE, valid_out 0, busy_out 0, result_out 0, multiplier registers 0, regardless of clock.
REQ-026b Reset asserted mid-multiply SHALL abort it; no result SHALL be produced after release.
REQ-026c ready_out SHALL be 1 in the first cycle after rst_n_in deasserts.

Configuration
REQ-026 Macro ALU_PIPE_MUL_EN: when defined, uop 0101 MUL (low DATA_WIDTH bits of unsigned A*B) and 0110 MULHU (high DATA_WIDTH bits) SHALL use an iterative shift-add multiplier, one bit per cycle, valid_out rising exactly DATA_WIDTH+1 edges after acceptance.
REQ-027 When ALU_PIPE_MUL_EN is undefined, 0101/0110 SHALL behave as single-cycle ops yielding 0, state MUL SHALL be unreachable, busy_out SHALL be tied 0, and no multiplier logic SHALL be synthesised.

Verification
REQ-028 Reset released, ready_in=1, ADD A=0xFFFFFFFF B=0x00000002 -> next cycle valid_out=1, result_out=0x00000001.
REQ-029 SRA A=0x80000000 B=0x00000024 -> result_out=0xF8000000 (shift 4); SLT A=0xFFFFFFFF B=0x00000001 -> 0x1; SLTU same operands -> 0x0.
REQ-030 ready_in=0, issue SUB 5-7 -> result_out=0xFFFFFFFE held, ready_out=0; 3 cycles later ready_in=1 with new OR request -> consume and accept on same edge, next result follows with no bubble.
REQ-031 ALU_PIPE_MUL_EN defined: MUL A=0x00010000 B=0x00010000 -> busy_out=1 for 32 cycles, valid_out on edge 33 with result_out=0x00000000; MULHU same -> 0x00000001.
REQ-032 rst_n_in pulsed low 10 cycles into a MUL -> valid_out=0, busy_out=0 immediately; no valid_out after release; next ADD 1+1 returns 0x00000002.
REQ-033 ALU_PIPE_MUL_EN undefined: uop 0101 A=3 B=4 -> 1-cycle latency, result_out=0x00000000, busy_out never 1.
